// File: rtl/vmask_unit_if.sv
// Beat-in / result-out bundle for vmask_unit.
// The producer side (e.g. a bench or dispatch stage) takes master; the unit takes slave.
interface vmask_unit_if #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned OPSEL_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0]  in_addr;
    logic [DATA_WIDTH-1:0]  in_m0;
    logic [DATA_WIDTH-1:0]  in_m1;
    logic                   in_valid;
    logic                   in_last;
    logic [OPSEL_WIDTH-1:0] in_opSel;
    logic [ADDR_WIDTH-1:0]  out_addr;
    logic [DATA_WIDTH-1:0]  out_vec;
    logic                   out_valid;

    modport master (
        output in_addr, in_m0, in_m1, in_valid, in_last, in_opSel,
        input  out_addr, out_vec, out_valid
    );

    modport slave (
        input  in_addr, in_m0, in_m1, in_valid, in_last, in_opSel,
        output out_addr, out_vec, out_valid
    );
endinterface

// File: rtl/vmask_unit.sv
// Mask-register unit: bitwise mask logicals plus multi-beat vcpop/vfirst/vmsbf/vmsif/vmsof,
// with a fixed-latency result pipeline carrying the destination address.
module vmask_unit #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned OPSEL_WIDTH = 4,
    parameter int unsigned PIPE_STAGES = 5,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic        clk,
    input  logic        rst,
    vmask_unit_if.slave bus
);
    localparam int unsigned IdxShift = $clog2(DATA_WIDTH);

    localparam logic [OPSEL_WIDTH-1:0] OpAndNot = OPSEL_WIDTH'(0);
    localparam logic [OPSEL_WIDTH-1:0] OpAnd    = OPSEL_WIDTH'(1);
    localparam logic [OPSEL_WIDTH-1:0] OpOr     = OPSEL_WIDTH'(2);
    localparam logic [OPSEL_WIDTH-1:0] OpXor    = OPSEL_WIDTH'(3);
    localparam logic [OPSEL_WIDTH-1:0] OpOrNot  = OPSEL_WIDTH'(4);
    localparam logic [OPSEL_WIDTH-1:0] OpNand   = OPSEL_WIDTH'(5);
    localparam logic [OPSEL_WIDTH-1:0] OpNor    = OPSEL_WIDTH'(6);
    localparam logic [OPSEL_WIDTH-1:0] OpXnor   = OPSEL_WIDTH'(7);
    localparam logic [OPSEL_WIDTH-1:0] OpCpop   = OPSEL_WIDTH'(8);
    localparam logic [OPSEL_WIDTH-1:0] OpFirst  = OPSEL_WIDTH'(9);
    localparam logic [OPSEL_WIDTH-1:0] OpMsbf   = OPSEL_WIDTH'(10);
    localparam logic [OPSEL_WIDTH-1:0] OpMsif   = OPSEL_WIDTH'(11);
    localparam logic [OPSEL_WIDTH-1:0] OpMsof   = OPSEL_WIDTH'(12);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e                 state_q, state_d;
    logic [OPSEL_WIDTH-1:0] op_q, op_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   beat_idx_q, beat_idx_d;
    logic                   found_q, found_d;

    logic                   s0_valid;
    logic [DATA_WIDTH-1:0]  s0_data;
    logic [ADDR_WIDTH-1:0]  s0_addr;

    logic                   pipe_valid_q [PIPE_STAGES];
    logic [DATA_WIDTH-1:0]  pipe_data_q  [PIPE_STAGES];
    logic [ADDR_WIDTH-1:0]  pipe_addr_q  [PIPE_STAGES];

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_WIDTH; i++) n = n + CNT_WIDTH'(v[i]);
        return n;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] lowest_idx(input logic [DATA_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] idx;
        idx = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) if (v[i]) idx = CNT_WIDTH'(i);
        return idx;
    endfunction

    logic                   accum;
    logic [OPSEL_WIDTH-1:0] eff_op;
    logic [DATA_WIDTH-1:0]  m0, m1, e, iso, msbf, msif;
    logic [CNT_WIDTH-1:0]   base_cnt, base_idx, acc_cnt, pos;
    logic                   base_found, acc_found, is_mask;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        beat_idx_d = beat_idx_q;
        found_d    = found_q;
        s0_valid   = 1'b0;
        s0_data    = '0;

        m0     = bus.in_m0;
        m1     = bus.in_m1;
        accum  = (state_q == StAccum);
        // Once a sequence is open, the latched op wins over whatever in_opSel says.
        eff_op = accum ? op_q : bus.in_opSel;
        is_mask = (eff_op >= OpCpop) && (eff_op <= OpMsof);

        base_cnt   = accum ? cnt_q : '0;
        base_idx   = accum ? beat_idx_q : '0;
        base_found = accum ? found_q : 1'b0;

        e    = m0 & m1;
        iso  = e & (-e);
        // iso - 1 is all-ones when e == 0, which is exactly the vmsbf/vmsif no-hit case.
        msbf = iso - DATA_WIDTH'(1);
        msif = msbf | iso;
        pos  = (base_idx << IdxShift) + lowest_idx(e);

        acc_cnt   = base_cnt;
        acc_found = base_found;

        if (bus.in_valid) begin
            if (!is_mask) begin
                s0_valid = 1'b1;
                case (eff_op)
                    OpAndNot: s0_data = m0 & ~m1;
                    OpAnd:    s0_data = m0 & m1;
                    OpOr:     s0_data = m0 | m1;
                    OpXor:    s0_data = m0 ^ m1;
                    OpOrNot:  s0_data = m0 | ~m1;
                    OpNand:   s0_data = ~(m0 & m1);
                    OpNor:    s0_data = ~(m0 | m1);
                    OpXnor:   s0_data = ~(m0 ^ m1);
                    default:  s0_data = '0;
                endcase
            end else begin
                case (eff_op)
                    OpCpop: begin
                        acc_cnt = base_cnt + popcount(e);
                        if (bus.in_last) begin
                            s0_valid = 1'b1;
                            s0_data  = DATA_WIDTH'(acc_cnt);
                        end
                    end
                    OpFirst: begin
                        if (!base_found && (e != '0)) begin
                            acc_cnt   = pos;
                            acc_found = 1'b1;
                        end
                        if (bus.in_last) begin
                            s0_valid = 1'b1;
                            s0_data  = acc_found ? DATA_WIDTH'(acc_cnt) : '1;
                        end
                    end
                    default: begin
                        s0_valid  = 1'b1;
                        acc_found = base_found | (e != '0);
                        if (!base_found) begin
                            case (eff_op)
                                OpMsbf:  s0_data = msbf;
                                OpMsif:  s0_data = msif;
                                default: s0_data = iso;
                            endcase
                        end
                    end
                endcase

                op_d = eff_op;
                if (bus.in_last) begin
                    state_d    = StIdle;
                    cnt_d      = '0;
                    found_d    = 1'b0;
                    beat_idx_d = '0;
                end else begin
                    state_d    = StAccum;
                    cnt_d      = acc_cnt;
                    found_d    = acc_found;
                    beat_idx_d = base_idx + CNT_WIDTH'(1);
                end
            end
        end

        s0_addr = s0_valid ? bus.in_addr : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= '0;
            cnt_q      <= '0;
            beat_idx_q <= '0;
            found_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            beat_idx_q <= beat_idx_d;
            found_q    <= found_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_data_q[i]  <= '0;
                pipe_addr_q[i]  <= '0;
            end
        end else begin
            pipe_valid_q[0] <= s0_valid;
            pipe_data_q[0]  <= s0_data;
            pipe_addr_q[0]  <= s0_addr;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_data_q[i]  <= pipe_data_q[i-1];
                pipe_addr_q[i]  <= pipe_addr_q[i-1];
            end
        end
    end

    assign bus.out_valid = pipe_valid_q[PIPE_STAGES-1];
    assign bus.out_vec   = pipe_data_q[PIPE_STAGES-1];
    assign bus.out_addr  = pipe_addr_q[PIPE_STAGES-1];
endmodule

// File: tb/tb_vmask_unit.sv
// Directed bench for vmask_unit: every result is checked for value, address and exact latency,
// and the number of results per group is checked so silent beats stay silent.
module tb_vmask_unit;
    localparam int unsigned DW   = 64;
    localparam int unsigned AW   = 32;
    localparam int unsigned OW   = 4;
    localparam int unsigned PIPE = 5;
    localparam int unsigned CW   = 32;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M0P  = 64'hF0F0_F0F0_F0F0_F0F0;
    localparam logic [63:0] M1P  = 64'hFF00_FF00_FF00_FF00;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;

    vmask_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPSEL_WIDTH(OW)) bus ();

    vmask_unit #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .OPSEL_WIDTH(OW),
        .PIPE_STAGES(PIPE),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] got_vec [$];
    logic [63:0] got_addr[$];
    int          got_cyc [$];
    logic [63:0] exp_vec [$];
    logic [63:0] exp_addr[$];
    int          exp_cyc [$];

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            got_vec.push_back(bus.out_vec);
            got_addr.push_back(64'(bus.out_addr));
            got_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one beat for one cycle; when has_out, queue the result due PIPE cycles later.
    task automatic send(input logic [3:0] op, input logic [63:0] m0, input logic [63:0] m1,
                        input logic last, input logic [31:0] addr, input logic has_out,
                        input logic [63:0] exp);
        bus.in_valid = 1'b1;
        bus.in_opSel = op;
        bus.in_m0    = m0;
        bus.in_m1    = m1;
        bus.in_last  = last;
        bus.in_addr  = addr;
        if (has_out) begin
            exp_vec.push_back(exp);
            exp_addr.push_back(64'(addr));
            exp_cyc.push_back(cyc + PIPE);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_opSel = '0;
        bus.in_m0    = '0;
        bus.in_m1    = '0;
        bus.in_last  = 1'b0;
        bus.in_addr  = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic verify(input string tag);
        int n;
        idle(PIPE + 3);
        check_eq($sformatf("%s_count", tag), 64'(got_vec.size()), 64'(exp_vec.size()));
        n = (got_vec.size() < exp_vec.size()) ? got_vec.size() : exp_vec.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_vec%0d", tag, i), got_vec[i], exp_vec[i]);
            check_eq($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
            check_eq($sformatf("%s_lat%0d", tag, i), 64'(got_cyc[i]), 64'(exp_cyc[i]));
        end
        got_vec.delete();
        got_addr.delete();
        got_cyc.delete();
        exp_vec.delete();
        exp_addr.delete();
        exp_cyc.delete();
    endtask

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        idle(3);
        check_eq("reset_valid", 64'(bus.out_valid), 64'd0);
        check_eq("reset_vec", bus.out_vec, 64'd0);
        check_eq("reset_addr", 64'(bus.out_addr), 64'd0);
        rst = 1'b0;
        idle(2);

        // Bitwise ops on a fixed pair, issued back to back, plus a reserved opcode.
        send(4'h1, M0P, M1P, 1'b0, 32'h100, 1'b1, 64'hF000_F000_F000_F000);
        send(4'h0, M0P, M1P, 1'b1, 32'h104, 1'b1, 64'h00F0_00F0_00F0_00F0);
        send(4'h2, M0P, M1P, 1'b0, 32'h108, 1'b1, 64'hFFF0_FFF0_FFF0_FFF0);
        send(4'h3, M0P, M1P, 1'b0, 32'h10C, 1'b1, 64'h0FF0_0FF0_0FF0_0FF0);
        send(4'h4, M0P, M1P, 1'b0, 32'h110, 1'b1, 64'hF0FF_F0FF_F0FF_F0FF);
        send(4'h5, M0P, M1P, 1'b0, 32'h114, 1'b1, 64'h0FFF_0FFF_0FFF_0FFF);
        send(4'h6, M0P, M1P, 1'b0, 32'h118, 1'b1, 64'h000F_000F_000F_000F);
        send(4'h7, M0P, M1P, 1'b0, 32'h11C, 1'b1, 64'hF00F_F00F_F00F_F00F);
        send(4'hD, M0P, M1P, 1'b0, 32'h120, 1'b1, 64'd0);
        verify("logic");

        // vcpop over three beats: popcounts 64, 1, 0.
        send(4'h8, ONES, ONES, 1'b0, 32'h200, 1'b0, 64'd0);
        send(4'h8, 64'h1, ONES, 1'b0, 32'h208, 1'b0, 64'd0);
        send(4'h8, 64'hFF, 64'h0, 1'b1, 32'h210, 1'b1, 64'd65);
        verify("vcpop3");

        // vfirst: hit in beat 1 at bit 4, then a sequence with no hit at all.
        send(4'h9, 64'h0, ONES, 1'b0, 32'h300, 1'b0, 64'd0);
        send(4'h9, 64'h10, ONES, 1'b1, 32'h308, 1'b1, 64'd68);
        send(4'h9, ONES, 64'h0, 1'b0, 32'h310, 1'b0, 64'd0);
        send(4'h9, 64'h0, ONES, 1'b1, 32'h318, 1'b1, ONES);
        verify("vfirst");

        // vmsif / vmsof / vmsbf, including a beat after the first hit.
        send(4'hB, 64'h0, ONES, 1'b0, 32'h400, 1'b1, ONES);
        send(4'hB, 64'h4, ONES, 1'b1, 32'h408, 1'b1, 64'h7);
        send(4'hC, 64'h0, ONES, 1'b0, 32'h410, 1'b1, 64'h0);
        send(4'hC, 64'h4, ONES, 1'b1, 32'h418, 1'b1, 64'h4);
        send(4'hA, 64'h8, ONES, 1'b0, 32'h420, 1'b1, 64'h7);
        send(4'hA, 64'h1, ONES, 1'b1, 32'h428, 1'b1, 64'h0);
        verify("vmsxf");

        // vcpop last beat, logical op next cycle, then a fresh vcpop that must start at 0.
        send(4'h8, 64'hFF, ONES, 1'b1, 32'h500, 1'b1, 64'd8);
        send(4'h3, 64'hAA, 64'h0F, 1'b0, 32'h504, 1'b1, 64'hA5);
        send(4'h8, 64'h3, ONES, 1'b1, 32'h508, 1'b1, 64'd2);
        // A logical opSel mid-sequence is ignored in favour of the latched vcpop.
        send(4'h8, 64'hF, ONES, 1'b0, 32'h510, 1'b0, 64'd0);
        send(4'h1, 64'h3, ONES, 1'b1, 32'h518, 1'b1, 64'd6);
        verify("b2b");

        // Async reset with three logical beats in flight and an open vcpop sequence.
        send(4'h1, M0P, M1P, 1'b0, 32'h600, 1'b0, 64'd0);
        send(4'h1, M0P, M1P, 1'b0, 32'h604, 1'b0, 64'd0);
        send(4'h1, M0P, M1P, 1'b0, 32'h608, 1'b0, 64'd0);
        send(4'h8, ONES, ONES, 1'b0, 32'h60C, 1'b0, 64'd0);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("midrst_vec", bus.out_vec, 64'd0);
        idle(2);
        rst = 1'b0;
        verify("midrst");
        send(4'h8, 64'h1, ONES, 1'b1, 32'h700, 1'b1, 64'd1);
        verify("postrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
